// File: rtl/mipi_csi_packet_encoder.sv
// CSI-2 packet framer: sync word, ECC-protected header, pass-through payload, CRC footer, idle trail.
// Define MIPI_CSI_TX_CRC_EN to compute the payload CRC16; otherwise the footer carries 16'h0000.
module mipi_csi_packet_encoder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
    parameter int unsigned TRAIL_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pkt_req_i,
    input  logic [5:0]  pkt_dt_i,
    input  logic [1:0]  pkt_vc_i,
    input  logic [15:0] pkt_wc_i,
    output logic        pkt_ack_o,
    input  logic [31:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {IDLE, SYNC, HEADER, PAYLOAD, FOOTER, TRAIL} state_t;

    localparam logic [3:0] TRAIL_LD = 4'(TRAIL_CYCLES);

    state_t      state_q, state_d;
    logic [5:0]  dt_q, dt_d;
    logic [1:0]  vc_q, vc_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  trail_q, trail_d;
    logic [15:0] crc_q;
    logic [31:0] data_d;
    logic        valid_d, ack_d, err_d, ready_d, busy_d;
    logic [23:0] hdr24;

    // Each parity bit covers a fixed subset of the 24 header bits (CSI-2 Hamming ECC).
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

`ifdef MIPI_CSI_TX_CRC_EN
    logic [15:0] crc_d;

    // Reflected CRC16, four bytes per call in lane order 0..3, LSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int b = 0; b < 4; b++) begin
            r = r ^ {8'h00, w[8*b +: 8]};
            for (int i = 0; i < 8; i++)
                r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) crc_q <= 16'hFFFF;
        else          crc_q <= crc_d;
    end
`else
    assign crc_q = 16'h0000;
`endif

    assign hdr24 = {wc_q, vc_q, dt_q};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Outputs for the next cycle are decided here and registered below, so every output is a flop.
    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        vc_d    = vc_q;
        wc_d    = wc_q;
        cnt_d   = cnt_q;
        trail_d = trail_q;
        data_d  = 32'h0;
        valid_d = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef MIPI_CSI_TX_CRC_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (pkt_req_i) begin
                    if (pkt_dt_i > 6'h0F && (pkt_wc_i == 16'h0 || pkt_wc_i[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end else begin
                        dt_d    = pkt_dt_i;
                        vc_d    = pkt_vc_i;
                        wc_d    = pkt_wc_i;
                        cnt_d   = pkt_wc_i;
                        ack_d   = 1'b1;
                        state_d = SYNC;
`ifdef MIPI_CSI_TX_CRC_EN
                        crc_d   = 16'hFFFF;
`endif
                    end
                end
            end
            SYNC: begin
                data_d  = {4{SYNC_BYTE}};
                valid_d = 1'b1;
                state_d = HEADER;
            end
            HEADER: begin
                data_d  = {2'b00, ecc6(hdr24), hdr24};
                valid_d = 1'b1;
                if (dt_q > 6'h0F) begin
                    state_d = PAYLOAD;
                end else begin
                    state_d = TRAIL;
                    trail_d = TRAIL_LD;
                end
            end
            PAYLOAD: begin
                if (pix_valid_i && pix_ready_o) begin
                    data_d  = pix_data_i;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - 16'd4;
`ifdef MIPI_CSI_TX_CRC_EN
                    crc_d   = crc16_word(crc_q, pix_data_i);
`endif
                    if (cnt_q == 16'd4) state_d = FOOTER;
                end
            end
            FOOTER: begin
                data_d  = {16'h0000, crc_q};
                valid_d = 1'b1;
                state_d = TRAIL;
                trail_d = TRAIL_LD;
            end
            TRAIL: begin
                if (trail_q <= 4'd1) state_d = IDLE;
                else                 trail_d = trail_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == PAYLOAD);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dt_q         <= 6'h0;
            vc_q         <= 2'h0;
            wc_q         <= 16'h0;
            cnt_q        <= 16'h0;
            trail_q      <= 4'h0;
            data_o       <= 32'h0;
            data_valid_o <= 1'b0;
            pkt_ack_o    <= 1'b0;
            err_o        <= 1'b0;
            pix_ready_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            dt_q         <= dt_d;
            vc_q         <= vc_d;
            wc_q         <= wc_d;
            cnt_q        <= cnt_d;
            trail_q      <= trail_d;
            data_o       <= data_d;
            data_valid_o <= valid_d;
            pkt_ack_o    <= ack_d;
            err_o        <= err_d;
            pix_ready_o  <= ready_d;
            busy_o       <= busy_d;
        end
    end

endmodule

// File: tb/tb_mipi_csi_packet_encoder.sv
// Bench for mipi_csi_packet_encoder: request table plus stall, reset and build-dependent footer sequences.
module tb_mipi_csi_packet_encoder;

    localparam int TRAIL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_req;
    logic [5:0]  pkt_dt;
    logic [1:0]  pkt_vc;
    logic [15:0] pkt_wc;
    logic        pkt_ack_o;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready_o;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic        busy_o;
    logic        err_o;

    always #5 clk = ~clk;

    mipi_csi_packet_encoder #(.SYNC_BYTE(8'hB8), .TRAIL_CYCLES(TRAIL)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .pkt_req_i(pkt_req), .pkt_dt_i(pkt_dt), .pkt_vc_i(pkt_vc), .pkt_wc_i(pkt_wc),
        .pkt_ack_o(pkt_ack_o),
        .pix_data_i(pix_data), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic [5:0]  dt;
        logic [1:0]  vc;
        logic [15:0] wc;
        bit          rej;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] pay[4];
    logic [31:0] exp_q[$];
    logic [31:0] obs[$];
    int          vtime[$];
    int          cyc, errors, checks, acks, errs_seen, last_vld, busy_fall;
    int          n_acc, n_rej;
    logic        busy_prev, mon_en;
    logic [31:0] e_word;

    // Scoreboard: every valid output word must be the next expected word; idle cycles carry zero.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_en) begin
            if (data_valid_o === 1'b1) begin
                checks = checks + 1;
                obs.push_back(data_o);
                vtime.push_back(cyc);
                last_vld = cyc;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_word got=%h exp=<none>", data_o);
                end else begin
                    e_word = exp_q.pop_front();
                    if (data_o !== e_word) begin
                        errors = errors + 1;
                        $display("FAIL data_word got=%h exp=%h", data_o, e_word);
                    end
                end
            end else begin
                checks = checks + 1;
                if (data_valid_o !== 1'b0 || data_o !== 32'h0) begin
                    errors = errors + 1;
                    $display("FAIL idle_zero got=%h/%b exp=00000000/0", data_o, data_valid_o);
                end
            end
            if (pkt_ack_o === 1'b1) acks = acks + 1;
            if (err_o === 1'b1) errs_seen = errs_seen + 1;
            if (busy_prev === 1'b1 && busy_o === 1'b0) busy_fall = cyc;
            busy_prev = busy_o;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ecc_ref(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Bit-serial reflected CRC: the word's bits in ascending order equal lane 0..3, LSB first.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 32; i++) begin
            fb = r[0] ^ w[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            errors = errors + 1;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    task automatic run_pkt(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                           input bit rej, input int gap, input bit wiggle);
        logic [23:0] h;
        logic [15:0] c;
        int nw, k;
        h = {wc, vc, dt};
        pkt_dt = dt; pkt_vc = vc; pkt_wc = wc; pkt_req = 1'b1;
        if (!rej) begin
            exp_q.push_back(32'hB8B8B8B8);
            exp_q.push_back({2'b00, ecc_ref(h), h});
            n_acc++;
        end else begin
            n_rej++;
        end
        step();
        pkt_req = wiggle;
        if (wiggle) begin
            pkt_dt = ~dt; pkt_vc = ~vc; pkt_wc = ~wc;
        end
        check("ack", {31'h0, pkt_ack_o}, {31'h0, !rej});
        check("err", {31'h0, err_o}, {31'h0, rej});
        if (!rej && dt > 6'h0F) begin
            c  = 16'hFFFF;
            nw = int'(wc) / 4;
            for (int i = 0; i < nw; i++) begin
                if (i > 0) repeat (gap) step();
                k = 0;
                while (pix_ready_o !== 1'b1 && k < 20) begin
                    step();
                    k++;
                end
                if (k >= 20) begin
                    errors = errors + 1;
                    $display("FAIL ready_timeout got=0 exp=1");
                end
                pix_data = pay[i]; pix_valid = 1'b1;
                exp_q.push_back(pay[i]);
                c = crc_ref(c, pay[i]);
                step();
                pix_valid = 1'b0; pix_data = 32'hDEADBEEF;
            end
`ifdef MIPI_CSI_TX_CRC_EN
            exp_q.push_back({16'h0000, c});
`else
            exp_q.push_back(32'h00000000);
`endif
        end
        pkt_req = 1'b0;
        wait_idle();
        @(negedge clk);
        #1;
        if (!rej) check("trail_len", busy_fall - last_vld, TRAIL);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    int gap_a, gap_b;
    logic [31:0] foot_a;

    initial begin
        cyc = 0; errors = 0; checks = 0; acks = 0; errs_seen = 0;
        last_vld = 0; busy_fall = 0; n_acc = 0; n_rej = 0;
        busy_prev = 1'b0; mon_en = 1'b0;
        rst_n = 1'b0; pkt_req = 1'b0; pkt_dt = '0; pkt_vc = '0; pkt_wc = '0;
        pix_data = '0; pix_valid = 1'b0;

        vecs[0] = '{6'h00, 2'd0, 16'h0000, 1'b0};
        vecs[1] = '{6'h01, 2'd2, 16'h1234, 1'b0};
        vecs[2] = '{6'h0F, 2'd3, 16'hFFFF, 1'b0};
        vecs[3] = '{6'h10, 2'd1, 16'h0004, 1'b0};
        vecs[4] = '{6'h2B, 2'd0, 16'h0008, 1'b0};
        vecs[5] = '{6'h2C, 2'd0, 16'h0006, 1'b1};
        vecs[6] = '{6'h2C, 2'd0, 16'h0000, 1'b1};
        vecs[7] = '{6'h24, 2'd1, 16'h0003, 1'b1};
        vecs[8] = '{6'h2A, 2'd2, 16'h000C, 1'b0};

        repeat (3) step();
        check("rst_data",  data_o, 32'h0);
        check("rst_valid", {31'h0, data_valid_o}, 32'h0);
        check("rst_ready", {31'h0, pix_ready_o}, 32'h0);
        check("rst_ack",   {31'h0, pkt_ack_o}, 32'h0);
        check("rst_busy",  {31'h0, busy_o}, 32'h0);
        check("rst_err",   {31'h0, err_o}, 32'h0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 4; j++) pay[j] = $urandom;
            run_pkt(vecs[i].dt, vecs[i].vc, vecs[i].wc, vecs[i].rej, (i == 8) ? 1 : 0, (i == 1 || i == 8));
        end

        // Long packet with and without a 3-cycle payload stall: same footer, exact gap.
        pay[0] = 32'h03020100; pay[1] = 32'hA5A55A5A;
        obs.delete(); vtime.delete();
        run_pkt(6'h2B, 2'd0, 16'h0008, 1'b0, 0, 1'b0);
        check("long_words", obs.size(), 5);
        if (obs.size() == 5) begin
            check("long_hdr", {8'h0, obs[1][23:0]}, 32'h0000082B);
            gap_a  = vtime[3] - vtime[2];
            foot_a = obs[4];
            check("nostall_gap", gap_a, 1);
        end
        obs.delete(); vtime.delete();
        run_pkt(6'h2B, 2'd0, 16'h0008, 1'b0, 3, 1'b0);
        check("stall_words", obs.size(), 5);
        if (obs.size() == 5) begin
            gap_b = vtime[3] - vtime[2];
            check("stall_gap", gap_b, 4);
            check("stall_footer", obs[4], foot_a);
        end

        // Reset in the middle of the payload, then a normal short packet.
        pkt_dt = 6'h2B; pkt_vc = 2'd0; pkt_wc = 16'h0008; pkt_req = 1'b1;
        exp_q.push_back(32'hB8B8B8B8);
        exp_q.push_back({2'b00, ecc_ref(24'h00082B), 24'h00082B});
        step();
        pkt_req = 1'b0;
        begin
            int k;
            k = 0;
            while (pix_ready_o !== 1'b1 && k < 20) begin
                step();
                k++;
            end
            check("rst_mid_ready", {31'h0, pix_ready_o}, 32'h1);
        end
        pix_data = 32'h11223344; pix_valid = 1'b1;
        exp_q.push_back(32'h11223344);
        step();
        pix_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("abort_valid", {31'h0, data_valid_o}, 32'h0);
        check("abort_ready", {31'h0, pix_ready_o}, 32'h0);
        check("abort_busy",  {31'h0, busy_o}, 32'h0);
        rst_n = 1'b1;
        repeat (4) step();
        check("abort_drained", exp_q.size(), 0);
        n_acc++;
        run_pkt(6'h05, 2'd1, 16'hBEEF, 1'b0, 0, 1'b0);

        check("ack_count", acks, n_acc);
        check("err_count", errs_seen, n_rej);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mipi_csi_packet_encoder.md
MIPI_CSI_PACKET_ENCODER -- requirements
Module: mipi_csi_packet_encoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hB8: leader byte replicated on all four lanes.
REQ-002 SHALL have parameter TRAIL_CYCLES, default 1: idle cycles forced after every packet, legal range 1..15.
REQ-003 SHALL have port clk_i, input, 1: MIPI byte clock, the only clock in the block.
REQ-004 SHALL have port rst_n_i, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port pkt_req_i, input, 1: packet request, level-sensitive.
REQ-006 SHALL have port pkt_dt_i, input, 6: CSI-2 data type.
REQ-007 SHALL have port pkt_vc_i, input, 2: virtual channel.
REQ-008 SHALL have port pkt_wc_i, input, 16: word count for long packets, data field for short packets.
REQ-009 SHALL have port pkt_ack_o, output, 1: one-cycle pulse when a request is accepted.
REQ-010 SHALL have port pix_data_i, input, 32: payload bytes, lane0 = [7:0].
REQ-011 SHALL have port pix_valid_i, input, 1: payload word valid.
REQ-012 SHALL have port pix_ready_o, output, 1: payload word accepted when pix_valid_i && pix_ready_o.
REQ-013 SHALL have port data_o, output, 32: lane-aligned byte stream for the PHY, lane0 = [7:0].
REQ-014 SHALL have port data_valid_o, output, 1: data_o valid.
REQ-015 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-016 SHALL have port err_o, output, 1: one-cycle pulse when a request is rejected.

Function
REQ-017 States SHALL be: IDLE, SYNC, HEADER, PAYLOAD, FOOTER, TRAIL; all outputs SHALL be registered.
REQ-018 A packet is short when pkt_dt_i <= 6'h0F and long otherwise.
REQ-019 Request handling in IDLE with pkt_req_i=1 SHALL be:
- pkt_dt_i, pkt_vc_i and pkt_wc_i are latched.
- pkt_ack_o pulses.
- State moves to SYNC.
- Exception: a long packet with pkt_wc_i==0 or pkt_wc_i[1:0]!=0 is not accepted; err_o pulses instead and the state stays IDLE.
REQ-020 SYNC SHALL emit data_o={4{SYNC_BYTE}} with data_valid_o=1 in the cycle after acceptance, then go to HEADER.
REQ-021 HEADER SHALL emit data_o with:
- [7:0] = {vc,dt}
- [15:8] = wc[7:0]
- [23:16] = wc[15:8]
- [31:24] = {2'b00, ECC6}
ECC6 is the CSI-2 Hamming ECC over the 24 bits above. After HEADER: long packet -> PAYLOAD; short packet -> TRAIL.
REQ-022 Payload flow SHALL work as follows:
- pix_ready_o is 1 only in PAYLOAD.
- Each accepted word appears on data_o with data_valid_o=1 on the next cycle, unmodified.
- A cycle with no accepted word gives data_valid_o=0 (stall); a stall does not change state.
REQ-023 A 16-bit remaining-byte counter SHALL load wc at acceptance and decrement by 4 per accepted word; on the word that makes it 0, pix_ready_o drops the next cycle and the state moves to FOOTER.
REQ-024 FOOTER SHALL emit, on the cycle after the last payload word appears, data_o={16'h0000, CRC16} with data_valid_o=1, then go to TRAIL.
REQ-025 CRC16 SHALL use polynomial 0x8408 (reflected x^16+x^12+x^5+1), seed 0xFFFF, no final XOR, processing 4 bytes per cycle in lane order 0..3.
REQ-026 TRAIL SHALL hold data_valid_o=0 for TRAIL_CYCLES cycles, then return to IDLE; a request is never accepted in the same cycle as the TRAIL exit.
REQ-027 pkt_req_i and pkt_*_i SHALL be ignored outside IDLE; the latched header is not affected by input changes mid-packet.
REQ-028 When data_valid_o=0, data_o SHALL be 32'h0.

Reset
REQ-029 With rst_n_i=0 at a clock edge, the state SHALL go to IDLE and data_o, data_valid_o, pix_ready_o, pkt_ack_o, busy_o and err_o SHALL all be 0, with the counter at 0 and CRC at 0xFFFF.
REQ-030 Reset mid-packet SHALL abort the packet, with no footer or trail emitted; data_valid_o is 0 on the cycle after the reset edge.

Configuration
REQ-031 Macro MIPI_CSI_TX_CRC_EN SHALL control the CRC:
- Defined: FOOTER carries the computed CRC16.
- Undefined: no CRC logic is built and FOOTER carries 16'h0000 (CSI-2 "checksum not computed").

Verification
REQ-032 Short packet: dt=0x00, vc=0, wc=0 -> sync word 32'hB8B8B8B8, then header 32'h00000000, then TRAIL_CYCLES cycles of data_valid_o=0, with busy_o=0 afterwards.
REQ-033 Long packet: dt=0x2B, wc=8, two payload words without gaps -> B8B8B8B8, header [23:0]=24'h00082B, both payload words unchanged, then footer matching a golden CRC model.
REQ-034 Payload stall: same as REQ-033 with pix_valid_i=0 for 3 cycles between the words -> exactly 3 cycles of data_valid_o=0 in the payload, and a footer identical to the no-stall case.
REQ-035 Rejected request: dt=0x2C with wc=6, then wc=0 -> err_o pulses for each, no pkt_ack_o, data_valid_o stays 0.
REQ-036 Reset during PAYLOAD after one word -> data_valid_o=0 and pix_ready_o=0 on the next cycle; a new short request is then accepted normally.
REQ-037 Compare builds with MIPI_CSI_TX_CRC_EN defined and undefined on the REQ-033 stimulus -> footer is the CRC or 32'h00000000 respectively, all other words identical.
